versat_run_sequencer: RTL
=========================

// Module: versat_run_sequencer
// PURPOSE
//  Controller for a Versat accelerator instance: sequences N back-to-back runs of the datapath.
//  For each run it pulses run, waits for the aggregated done, and enforces an optional per-run timeout.
//  Raises a level interrupt at the end. The CPU sees it as a small register slave on the native
//  valid/addr/wdata/wstrb/ready/rdata bus, next to the accelerator's memory-mapped units.
// PARAMETERS
//  DATA_W  32  bus data width (>= 32)
//  ADDR_W  2   word-address width; 4 registers
//  CNT_W   16  width of the repeat count, run counter and timeout counter
// PORTS
//  clk     in   1          system clock; all logic on rising edge
//  rst     in   1          asynchronous, active-high reset
//  valid   in   1          CPU request
//  addr    in   ADDR_W     register word address
//  wstrb   in   DATA_W/8   write strobes; |wstrb=write, 0=read
//  wdata   in   DATA_W     write data
//  ready   out  1          request acknowledge, one-cycle pulse
//  rdata   out  DATA_W     read data, valid while ready=1, else 0
//  run     out  1          run pulse to the accelerator
//  done    in   1          accelerator aggregated done (AND of unit dones), level
//  irq     out  1          interrupt = done_flag | timeout_flag
// BEHAVIOUR
//  Reset: state=IDLE; run=0, ready=0, rdata=0, irq=0; repeat=1, timeout=0; counters=0; flags=0.
//  Registers:
//   0 CTRL     W: bit0 start, bit1 abort; reads 0
//   1 REPEAT   RW: CNT_W runs; 0 is treated as 1
//   2 TIMEOUT  RW: max cycles in WAIT per run; 0 = disabled
//   3 STATUS   R: {runs_done[CNT_W-1:0] at [31:16], timeout_flag[2], done_flag[1], busy[0]};
//              W1C bits 2:1
//  Bus: each valid cycle is one request; ready=1 exactly one cycle later, for one cycle.
//   rdata is registered at the same time. A partial wstrb writes the whole word (no byte lanes).
//  REPEAT/TIMEOUT writes while busy are dropped (ready still returned). Reads always allowed.
//  FSM:
//   IDLE  : CTRL write with start=1 and abort=0 -> clear runs_done and both flags -> RUN.
//   RUN   : run=1 for exactly this cycle; clear timer -> GUARD.
//   GUARD : one cycle; done ignored (it may still be high from the previous run) -> WAIT.
//   WAIT  : timer++ each cycle.
//           done=1: runs_done++; if runs_done+1 == max(REPEAT,1): set done_flag -> IDLE; else -> RUN.
//           TIMEOUT!=0 and timer == TIMEOUT-1 with done=0: set timeout_flag -> IDLE.
//  busy = (state != IDLE). Start while busy is ignored.
//  Abort (CTRL bit1) in any busy state: -> IDLE next cycle; no flag set; runs_done is kept.
//   Start and abort in the same write: abort wins; when IDLE nothing happens.
//  done and timeout in the same cycle: done wins.
//  Flag set and W1C in the same cycle: set wins.
//  runs_done wraps at 2^CNT_W (not reachable, since it is bounded by REPEAT).
//  Back-to-back runs: run pulses are spaced at least 3 cycles apart (RUN, GUARD, WAIT).
//  Reset mid-operation: immediate return to reset values; run drops asynchronously.
//  Latency: start write at cycle t -> ready and run both at t+1.
// TESTING
//  1 Reset, read STATUS -> ready 1 cycle after valid; rdata=0; run=0, irq=0.
//  2 REPEAT=3, TIMEOUT=0, start; model raises done 5 cycles after each run
//    -> exactly 3 run pulses; STATUS=0x0003_0002; irq=1; W1C 0x2 -> irq=0.
//  3 REPEAT=1, TIMEOUT=10, done never rises -> IDLE after 10 WAIT cycles; STATUS=0x0000_0004;
//    done rising at the timeout cycle instead -> done_flag.
//  4 done stuck high before start, REPEAT=2 -> GUARD masks it; runs complete one WAIT cycle
//    after each GUARD; 2 run pulses.
//  5 REPEAT=5 busy: write REPEAT=9, write start, then abort after 2nd done
//    -> REPEAT reads 5; no extra run; STATUS=0x0002_0000; irq=0.
//  6 Assert rst while in WAIT -> all outputs reset at once; a later start behaves as in test 2.

Source files
------------

// File: rtl/versat_run_sequencer.sv
// Run sequencer for a Versat accelerator: issues REPEAT back-to-back run pulses, waits for the
// aggregated done after each, enforces an optional per-run timeout and raises a level interrupt.
module versat_run_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                run,
    input  logic                done,
    output logic                irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] REG_CTRL    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_REPEAT  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_TIMEOUT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] REG_STATUS  = ADDR_W'(3);

    state_t              state_reg;
    logic [CNT_W-1:0]    repeat_reg;
    logic [CNT_W-1:0]    timeout_reg;
    logic [CNT_W-1:0]    runs_done_reg;
    logic [CNT_W-1:0]    timer_reg;
    logic                done_flag_reg;
    logic                timeout_flag_reg;
    logic                run_reg;
    logic                ready_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic                is_write;
    logic                is_read;
    logic                ctrl_write;
    logic                start_req;
    logic                abort_req;
    logic                busy;
    logic [CNT_W-1:0]    repeat_eff;
    logic [CNT_W-1:0]    runs_done_inc;
    logic                last_run;
    logic                timer_expired;
    logic [DATA_W-1:0]   status_word;
    logic [DATA_W-1:0]   read_word;
    logic                unused_wdata;

    assign is_write   = valid && (|wstrb);
    assign is_read    = valid && !(|wstrb);
    assign ctrl_write = is_write && (addr == REG_CTRL);
    assign start_req  = ctrl_write && wdata[0] && !wdata[1];
    assign abort_req  = ctrl_write && wdata[1];
    assign busy       = (state_reg != IDLE);

    // A programmed repeat of zero still performs a single run.
    assign repeat_eff    = (repeat_reg == '0) ? CNT_W'(1) : repeat_reg;
    assign runs_done_inc = runs_done_reg + CNT_W'(1);
    assign last_run      = (runs_done_inc == repeat_eff);
    assign timer_expired = (timeout_reg != '0) && (timer_reg == timeout_reg - CNT_W'(1));

    assign unused_wdata = &{1'b0, wdata[DATA_W-1:CNT_W]};

    always_comb begin
        status_word              = '0;
        status_word[16 +: CNT_W] = runs_done_reg;
        status_word[2]           = timeout_flag_reg;
        status_word[1]           = done_flag_reg;
        status_word[0]           = busy;
    end

    always_comb begin
        read_word = '0;
        case (addr)
            REG_REPEAT:  read_word = {{(DATA_W-CNT_W){1'b0}}, repeat_reg};
            REG_TIMEOUT: read_word = {{(DATA_W-CNT_W){1'b0}}, timeout_reg};
            REG_STATUS:  read_word = status_word;
            default:     read_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            repeat_reg       <= CNT_W'(1);
            timeout_reg      <= '0;
            runs_done_reg    <= '0;
            timer_reg        <= '0;
            done_flag_reg    <= 1'b0;
            timeout_flag_reg <= 1'b0;
            run_reg          <= 1'b0;
            ready_reg        <= 1'b0;
            rdata_reg        <= '0;
        end else begin
            ready_reg <= valid;
            rdata_reg <= is_read ? read_word : '0;
            run_reg   <= 1'b0;

            // Configuration is frozen while a sequence is in flight.
            if (!busy && is_write && addr == REG_REPEAT) begin
                repeat_reg <= wdata[CNT_W-1:0];
            end
            if (!busy && is_write && addr == REG_TIMEOUT) begin
                timeout_reg <= wdata[CNT_W-1:0];
            end

            // W1C first so that a flag set by the FSM in the same cycle takes precedence.
            if (is_write && addr == REG_STATUS) begin
                if (wdata[1]) done_flag_reg    <= 1'b0;
                if (wdata[2]) timeout_flag_reg <= 1'b0;
            end

            if (busy && abort_req) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_req) begin
                            runs_done_reg    <= '0;
                            done_flag_reg    <= 1'b0;
                            timeout_flag_reg <= 1'b0;
                            run_reg          <= 1'b1;
                            state_reg        <= RUN;
                        end
                    end
                    RUN: begin
                        timer_reg <= '0;
                        state_reg <= GUARD;
                    end
                    // done may still be high from the previous run, so it is not sampled here.
                    GUARD: begin
                        state_reg <= WAIT;
                    end
                    WAIT: begin
                        timer_reg <= timer_reg + CNT_W'(1);
                        if (done) begin
                            runs_done_reg <= runs_done_inc;
                            if (last_run) begin
                                done_flag_reg <= 1'b1;
                                state_reg     <= IDLE;
                            end else begin
                                run_reg   <= 1'b1;
                                state_reg <= RUN;
                            end
                        end else if (timer_expired) begin
                            timeout_flag_reg <= 1'b1;
                            state_reg        <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign ready = ready_reg;
    assign rdata = rdata_reg;
    assign run   = run_reg;
    assign irq   = done_flag_reg | timeout_flag_reg;

endmodule
